morph_frame_ctrl: RTL and testbench
===================================

Name: morph_frame_ctrl

Overview:
- Frame-level sequencer for two cascaded binary morphology stages (stage A, then stage B), each selectable as bypass, erode or dilate.
- Accepts operation requests over a valid/ready port and holds one pending request.
- Applies a pending request only between frames, after the morphology pipeline has drained.
- Checks per-frame geometry against IMG_HDISP×IMG_VDISP, counts completed frames and reports errors.

Parameters:
IMG_HDISP, 10'd640, expected clken pulses per href line
IMG_VDISP, 10'd480, expected href lines per vsync frame
PIPE_LAT, 8, cycles from last input pixel until the stage outputs are flushed (matrix plus logic latency of both stages)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  mode request valid
cfg_ready  out  1  pending slot empty
cfg_mode  in  3  0 bypass, 1 erode, 2 dilate, 3 open, 4 close, 5-7 illegal
per_frame_vsync  in  1  frame-valid, active high
per_frame_href  in  1  line-valid
per_frame_clken  in  1  pixel enable
stage_a_sel  out  2  00 bypass, 01 erode, 10 dilate
stage_b_sel  out  2  same encoding as stage_a_sel
busy  out  1  high in ACTIVE or DRAIN
frame_done  out  1  one-cycle pulse at frame completion
frame_err  out  1  one-cycle pulse with frame_done if any err_code bit is set
err_code  out  3  [0] line-length mismatch, [1] line-count mismatch, [2] short vblank; held until the next frame_done
frame_cnt  out  16  completed frames, wraps at 0xFFFF→0
err_cnt  out  8  erroneous frames (optional feature)

Behaviour:
- Reset values: stage_a_sel=stage_b_sel=00, busy=0, cfg_ready=1, frame_done=0, frame_err=0, err_code=0, frame_cnt=0, err_cnt=0. State = IDLE, armed=0.
- Edge detection uses one registered copy each of vsync and href, so every transition is acted on one cycle after it appears on the inputs.
- armed is set on the first cycle vsync is sampled low. No vsync rise is honoured until armed=1. Consequently, after a reset mid-frame the block waits for a full new frame.
- Handshake:
  - A transfer occurs when cfg_valid&&cfg_ready.
  - cfg_ready = !pending.
  - Mode-to-select mapping: 0 → A=00, B=00; 1 → A=01, B=00; 2 → A=10, B=00; 3 → A=01, B=10; 4 → A=10, B=01; 5-7 → treated as bypass.
- FSM:
  - IDLE: if pending, the stage selects update on the next edge and pending clears (cfg_ready rises one cycle later). A vsync rise moves to ACTIVE and clears the counters. If apply and vsync rise coincide, apply wins; the new selects are valid from the first pixel.
  - ACTIVE: hcnt counts clken while href is high, 10-bit, saturating at 1023.
    - On each href fall: if hcnt≠IMG_HDISP, set err[0]; increment vcnt (saturating); clear hcnt.
    - On vsync fall: if vcnt≠IMG_VDISP, set err[1]; load drain=PIPE_LAT-1 and go to DRAIN.
    - Selects and pending are never touched in ACTIVE; a request accepted mid-frame stays pending.
  - DRAIN: decrement drain.
    - At 0: go to IDLE; pulse frame_done; publish err_code; pulse frame_err if nonzero; frame_cnt+1.
    - If vsync rises during DRAIN: pulse frame_done immediately with err[2] set, go to ACTIVE, restart counters; pending is not applied.
- Simultaneous href fall and vsync fall: complete the line check first, then the frame check, within the same cycle.

Optional Feature:
MORPH_CTRL_ERRCNT_EN:
- Defined: err_cnt increments on each frame_err, saturating at 255; cleared only by reset.
- Undefined: err_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Package morph_ctrl_pkg: cfg_mode codes, select codes, state encoding (IDLE/ACTIVE/DRAIN), err_code bit indices.
- Sub-module morph_geom_checker: href/vsync edge detection, hcnt/vcnt counters and the err[1:0] compare. The parent keeps the FSM, config path and counters.

Test Plan:
- Reset, then cfg_mode=3 in IDLE → cfg_ready low one cycle, stage_a_sel=01 and stage_b_sel=10 one cycle after the transfer.
- One 640×480 frame, PIPE_LAT=8 → frame_done exactly 9 cycles after vsync falls on the inputs (1 detection + 8 drain); frame_cnt=1; err_code=0.
- cfg_mode=4 issued mid-frame → selects unchanged until frame_done; applied next cycle in IDLE (A=10, B=01); cfg_ready low throughout the frame.
- Frame with one 639-pixel line and 479 lines → frame_err pulse, err_code=3'b011; err_cnt=1 when MORPH_CTRL_ERRCNT_EN is defined, 0 otherwise.
- vsync re-rises 3 cycles after falling → frame_done with err_code[2]=1; pending mode kept pending; second frame runs with the old selects.
- Assert rst_n mid-frame with vsync held high → all outputs at reset values; nothing happens until vsync goes low then rises again.

Source files
------------

// File: rtl/morph_ctrl_pkg.sv
// Shared codes for the morphology frame sequencer: request modes, stage selects,
// FSM states and err_code bit positions.
package morph_ctrl_pkg;

   localparam logic [2:0] ModeBypass = 3'd0;
   localparam logic [2:0] ModeErode  = 3'd1;
   localparam logic [2:0] ModeDilate = 3'd2;
   localparam logic [2:0] ModeOpen   = 3'd3;
   localparam logic [2:0] ModeClose  = 3'd4;

   typedef enum logic [1:0] {
      SelBypass = 2'b00,
      SelErode  = 2'b01,
      SelDilate = 2'b10
   } sel_e;

   typedef struct packed {
      sel_e a;
      sel_e b;
   } sel_pair_t;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StActive = 2'd1,
      StDrain  = 2'd2
   } state_e;

   localparam int unsigned ErrLineBit   = 0;
   localparam int unsigned ErrCountBit  = 1;
   localparam int unsigned ErrVblankBit = 2;

   // Open = erode then dilate, close = dilate then erode; illegal codes fall back to bypass.
   function automatic sel_pair_t mode_to_sel(input logic [2:0] mode);
      sel_pair_t p;
      p.a = SelBypass;
      p.b = SelBypass;
      case (mode)
         ModeErode:  p.a = SelErode;
         ModeDilate: p.a = SelDilate;
         ModeOpen: begin
            p.a = SelErode;
            p.b = SelDilate;
         end
         ModeClose: begin
            p.a = SelDilate;
            p.b = SelErode;
         end
         default: p = '{a: SelBypass, b: SelBypass};
      endcase
      return p;
   endfunction

endpackage

// File: rtl/morph_geom_checker.sv
// Frame geometry checker: vsync/href edge detection, pixel/line counters and the
// line-length / line-count compare.
module morph_geom_checker
   import morph_ctrl_pkg::*;
#(
   parameter logic [9:0] IMG_HDISP = 10'd640,
   parameter logic [9:0] IMG_VDISP = 10'd480
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vsync_i,
   input  logic       href_i,
   input  logic       clken_i,
   input  logic       active_i,
   input  logic       clear_i,
   output logic       vs_rise_o,
   output logic       vs_fall_o,
   output logic [1:0] err_o
);

   logic       vsync_q, href_q;
   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;
   logic [9:0] vcnt_line;
   logic [1:0] err_q, err_d;
   logic       href_fall;

   assign vs_rise_o = vsync_i & ~vsync_q;
   assign vs_fall_o = ~vsync_i & vsync_q;
   assign href_fall = ~href_i & href_q;
   assign err_o     = err_q;

   always_comb begin
      hcnt_d    = hcnt_q;
      vcnt_d    = vcnt_q;
      err_d     = err_q;
      vcnt_line = vcnt_q;
      if (clear_i) begin
         hcnt_d = '0;
         vcnt_d = '0;
         err_d  = '0;
      end else if (active_i) begin
         if (href_fall) begin
            if (hcnt_q != IMG_HDISP) err_d[ErrLineBit] = 1'b1;
            vcnt_line = (vcnt_q == 10'h3FF) ? vcnt_q : vcnt_q + 10'd1;
            vcnt_d    = vcnt_line;
            hcnt_d    = '0;
         end else if (href_i && clken_i && hcnt_q != 10'h3FF) begin
            hcnt_d = hcnt_q + 10'd1;
         end
         // A line ending on the same cycle as the frame is counted before the frame check.
         if (vs_fall_o && vcnt_line != IMG_VDISP) err_d[ErrCountBit] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
         hcnt_q  <= '0;
         vcnt_q  <= '0;
         err_q   <= '0;
      end else begin
         vsync_q <= vsync_i;
         href_q  <= href_i;
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: rtl/morph_frame_ctrl.sv
// Frame-level sequencer for two cascaded morphology stages; mode requests are applied only
// between frames. Define MORPH_CTRL_ERRCNT_EN to build the erroneous-frame counter.
module morph_frame_ctrl
   import morph_ctrl_pkg::*;
#(
   parameter logic [9:0]  IMG_HDISP = 10'd640,
   parameter logic [9:0]  IMG_VDISP = 10'd480,
   parameter int unsigned PIPE_LAT  = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_valid_i,
   output logic        cfg_ready_o,
   input  logic [2:0]  cfg_mode_i,
   input  logic        per_frame_vsync_i,
   input  logic        per_frame_href_i,
   input  logic        per_frame_clken_i,
   output logic [1:0]  stage_a_sel_o,
   output logic [1:0]  stage_b_sel_o,
   output logic        busy_o,
   output logic        frame_done_o,
   output logic        frame_err_o,
   output logic [2:0]  err_code_o,
   output logic [15:0] frame_cnt_o,
   output logic [7:0]  err_cnt_o
);

   localparam int unsigned DrainW = (PIPE_LAT > 2) ? $clog2(PIPE_LAT) : 1;
   localparam logic [DrainW-1:0] DrainLoad = DrainW'(PIPE_LAT - 1);

   state_e            state_q, state_d;
   logic [DrainW-1:0] drain_q, drain_d;
   logic              armed_q, armed_d;
   logic              pending_q, pending_d;
   logic [2:0]        pend_mode_q, pend_mode_d;
   sel_pair_t         sel_q, sel_d;
   logic              frame_done_q, frame_done_d;
   logic              frame_err_q, frame_err_d;
   logic [2:0]        err_code_q, err_code_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic [2:0]        fin_code;

   logic       vs_rise_raw, vs_fall;
   logic       vs_rise;
   logic       geom_clear;
   logic [1:0] geom_err;

   morph_geom_checker #(
      .IMG_HDISP (IMG_HDISP),
      .IMG_VDISP (IMG_VDISP)
   ) u_geom (
      .clk       (clk),
      .rst_n     (rst_n),
      .vsync_i   (per_frame_vsync_i),
      .href_i    (per_frame_href_i),
      .clken_i   (per_frame_clken_i),
      .active_i  (state_q == StActive),
      .clear_i   (geom_clear),
      .vs_rise_o (vs_rise_raw),
      .vs_fall_o (vs_fall),
      .err_o     (geom_err)
   );

   // A frame already in flight at reset is ignored until vsync has been seen low.
   assign armed_d = armed_q | ~per_frame_vsync_i;
   assign vs_rise = vs_rise_raw & armed_q;

   always_comb begin
      state_d      = state_q;
      drain_d      = drain_q;
      pending_d    = pending_q;
      pend_mode_d  = pend_mode_q;
      sel_d        = sel_q;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;
      err_code_d   = err_code_q;
      frame_cnt_d  = frame_cnt_q;
      geom_clear   = 1'b0;
      fin_code     = {1'b0, geom_err};

      if (cfg_valid_i && !pending_q) begin
         pending_d   = 1'b1;
         pend_mode_d = cfg_mode_i;
      end

      unique case (state_q)
         StIdle: begin
            if (pending_q) begin
               sel_d     = mode_to_sel(pend_mode_q);
               pending_d = 1'b0;
            end
            if (vs_rise) begin
               state_d    = StActive;
               geom_clear = 1'b1;
            end
         end
         StActive: begin
            if (vs_fall) begin
               drain_d = DrainLoad;
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (vs_rise) begin
               fin_code[ErrVblankBit] = 1'b1;
               frame_done_d = 1'b1;
               frame_err_d  = 1'b1;
               err_code_d   = fin_code;
               frame_cnt_d  = frame_cnt_q + 16'd1;
               geom_clear   = 1'b1;
               state_d      = StActive;
            end else if (drain_q == '0) begin
               frame_done_d = 1'b1;
               frame_err_d  = |fin_code;
               err_code_d   = fin_code;
               frame_cnt_d  = frame_cnt_q + 16'd1;
               state_d      = StIdle;
            end else begin
               drain_d = drain_q - DrainW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         drain_q      <= '0;
         armed_q      <= 1'b0;
         pending_q    <= 1'b0;
         pend_mode_q  <= ModeBypass;
         sel_q        <= '{a: SelBypass, b: SelBypass};
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         err_code_q   <= '0;
         frame_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         drain_q      <= drain_d;
         armed_q      <= armed_d;
         pending_q    <= pending_d;
         pend_mode_q  <= pend_mode_d;
         sel_q        <= sel_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
         err_code_q   <= err_code_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

`ifdef MORPH_CTRL_ERRCNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else if (frame_err_d && err_cnt_q != 8'hFF) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign err_cnt_o = err_cnt_q;
`else
   assign err_cnt_o = '0;
`endif

   assign cfg_ready_o   = ~pending_q;
   assign stage_a_sel_o = sel_q.a;
   assign stage_b_sel_o = sel_q.b;
   assign busy_o        = (state_q != StIdle);
   assign frame_done_o  = frame_done_q;
   assign frame_err_o   = frame_err_q;
   assign err_code_o    = err_code_q;
   assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_morph_frame_ctrl.sv
// Bench for morph_frame_ctrl: directed frames from the test plan, then randomized frames
// checked against a frame-level model of modes, pending requests and error codes.
module tb_morph_frame_ctrl;

   localparam logic [9:0]  H   = 10'd12;
   localparam logic [9:0]  V   = 10'd6;
   localparam int unsigned Lat = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [2:0]  cfg_mode;
   logic        vsync, href, clken;
   logic [1:0]  sel_a, sel_b;
   logic        busy, frame_done, frame_err;
   logic [2:0]  err_code;
   logic [15:0] frame_cnt;
   logic [7:0]  err_cnt;

   int          n_chk = 0;
   int          n_pass = 0;
   int          done_seen = 0;
   int          done_tot = 0;
   int          n_frames = 0;
   int          n_errf = 0;
   bit          pend = 1'b0;
   logic [2:0]  pmode = 3'd0;
   logic [3:0]  exp_sel = 4'd0;

   morph_frame_ctrl #(
      .IMG_HDISP (H),
      .IMG_VDISP (V),
      .PIPE_LAT  (Lat)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .cfg_valid_i       (cfg_valid),
      .cfg_ready_o       (cfg_ready),
      .cfg_mode_i        (cfg_mode),
      .per_frame_vsync_i (vsync),
      .per_frame_href_i  (href),
      .per_frame_clken_i (clken),
      .stage_a_sel_o     (sel_a),
      .stage_b_sel_o     (sel_b),
      .busy_o            (busy),
      .frame_done_o      (frame_done),
      .frame_err_o       (frame_err),
      .err_code_o        (err_code),
      .frame_cnt_o       (frame_cnt),
      .err_cnt_o         (err_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_done === 1'b1) done_seen++;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish (checks so far %0d)", n_chk);
      $fatal(1);
   end

   // {stage A, stage B} expected for each request code
   function automatic logic [3:0] map_mode(input logic [2:0] m);
      case (m)
         3'd1:    return 4'b01_00;
         3'd2:    return 4'b10_00;
         3'd3:    return 4'b01_10;
         3'd4:    return 4'b10_01;
         default: return 4'b00_00;
      endcase
   endfunction

   function automatic logic [7:0] exp_err_cnt();
`ifdef MORPH_CTRL_ERRCNT_EN
      return 8'((n_errf > 255) ? 255 : n_errf);
`else
      return 8'd0;
`endif
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_sel(input string tag);
      check_eq({tag, "_sel_a"}, 32'(sel_a), 32'(exp_sel[3:2]));
      check_eq({tag, "_sel_b"}, 32'(sel_b), 32'(exp_sel[1:0]));
      check_eq({tag, "_ready"}, 32'(cfg_ready), 32'(!pend));
   endtask

   task automatic check_reset_vals();
      check_eq("rst_sel_a", 32'(sel_a), 32'd0);
      check_eq("rst_sel_b", 32'(sel_b), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_ready", 32'(cfg_ready), 32'd1);
      check_eq("rst_done", 32'(frame_done), 32'd0);
      check_eq("rst_ferr", 32'(frame_err), 32'd0);
      check_eq("rst_code", 32'(err_code), 32'd0);
      check_eq("rst_fcnt", 32'(frame_cnt), 32'd0);
      check_eq("rst_ecnt", 32'(err_cnt), 32'd0);
   endtask

   // Drive one line of exactly len pixel enables with random stalls.
   task automatic drive_line(input int len, input bit gap);
      int cnt;
      cnt  = 0;
      href = 1'b1;
      while (cnt < len) begin
         clken = ($urandom_range(0, 3) != 0);
         if (clken) cnt++;
         tick();
      end
      clken = 1'($urandom_range(0, 1));
      href  = 1'b0;
      if (gap) begin
         tick();
         clken = 1'($urandom_range(0, 1));
         tick();
         clken = 1'b0;
      end
   endtask

   task automatic check_done(input logic [2:0] code);
      n_frames++;
      done_tot++;
      if (code != 3'd0) n_errf++;
      check_eq("done_pulse", 32'(frame_done), 32'd1);
      check_eq("frame_err", 32'(frame_err), 32'(code != 3'd0));
      check_eq("err_code", 32'(err_code), 32'(code));
      check_eq("frame_cnt", 32'(frame_cnt), 32'(n_frames & 16'hFFFF));
      check_eq("err_cnt", 32'(err_cnt), 32'(exp_err_cnt()));
   endtask

   task automatic run_frame(input int nlines, input int bad_line, input int bad_len,
                            input bit merge, input bit midreq, input logic [2:0] midmode,
                            input bit short_vb, input bit idle_req, input logic [2:0] idle_mode);
      bit         e0;
      int         len;
      logic [2:0] code;
      e0    = 1'b0;
      vsync = 1'b1;
      tick();
      tick();
      check_eq("busy_active", 32'(busy), 32'd1);
      for (int l = 0; l < nlines; l++) begin
         if (l == 1) begin
            check_sel("frame");
            check_eq("done_seen", 32'(done_seen), 32'(done_tot));
            if (midreq && !pend) begin
               cfg_valid = 1'b1;
               cfg_mode  = midmode;
               tick();
               cfg_valid = 1'b0;
               pend      = 1'b1;
               pmode     = midmode;
            end
         end
         len = (l == bad_line) ? bad_len : int'(H);
         if (len != int'(H)) e0 = 1'b1;
         drive_line(len, !(merge && l == nlines - 1));
      end
      vsync = 1'b0;
      code  = {short_vb, nlines != int'(V), e0};
      tick();
      check_eq("busy_drain", 32'(busy), 32'd1);
      if (short_vb) begin
         tick();
         tick();
         check_eq("done_early_s", 32'(frame_done), 32'd0);
         vsync = 1'b1;
         tick();
         check_done(code);
         check_eq("busy_restart", 32'(busy), 32'd1);
         check_sel("short");
      end else begin
         repeat (Lat - 1) tick();
         check_eq("done_early", 32'(frame_done), 32'd0);
         tick();
         check_done(code);
         check_eq("busy_idle", 32'(busy), 32'd0);
         check_sel("at_done");
         tick();
         check_eq("done_one_cycle", 32'(frame_done), 32'd0);
         if (pend) begin
            exp_sel = map_mode(pmode);
            pend    = 1'b0;
         end
         check_sel("apply");
         if (idle_req) begin
            cfg_valid = 1'b1;
            cfg_mode  = idle_mode;
            tick();
            cfg_valid = 1'b0;
            check_eq("idle_ready_low", 32'(cfg_ready), 32'd0);
            tick();
            exp_sel = map_mode(idle_mode);
            check_sel("idle_apply");
         end
         repeat (3) tick();
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      cfg_mode  = 3'd0;
      vsync     = 1'b0;
      href      = 1'b0;
      clken     = 1'b0;
      #1;
      check_reset_vals();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();

      // open request in IDLE
      cfg_valid = 1'b1;
      cfg_mode  = 3'd3;
      tick();
      cfg_valid = 1'b0;
      check_eq("cfg3_ready_low", 32'(cfg_ready), 32'd0);
      check_eq("cfg3_sel_hold", 32'(sel_a), 32'd0);
      tick();
      exp_sel = 4'b01_10;
      check_sel("cfg3");

      run_frame(int'(V), -1, 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
      run_frame(int'(V), -1, 0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 3'd0);
      run_frame(int'(V) - 1, 2, int'(H) - 1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
      run_frame(int'(V), -1, 0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 3'd0);
      run_frame(int'(V), -1, 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd7);

      for (int f = 0; f < 24; f++) begin
         int nl, bl, blen;
         bit sv;
         nl   = ($urandom_range(0, 3) == 0) ? int'(V) + ($urandom_range(0, 1) ? 1 : -1)
                                            : int'(V);
         bl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
         blen = $urandom_range(0, 1) ? int'(H) - 1 : int'(H) + 2;
         sv   = (f != 23) && ($urandom_range(0, 4) == 0);
         run_frame(nl, bl, blen, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), sv, 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)));
      end

      // reset in the middle of a frame
      vsync = 1'b1;
      tick();
      tick();
      drive_line(int'(H), 1'b1);
      drive_line(int'(H), 1'b1);
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      tick();
      rst_n    = 1'b1;
      n_frames = 0;
      n_errf   = 0;
      pend     = 1'b0;
      exp_sel  = 4'd0;
      drive_line(int'(H), 1'b1);
      drive_line(int'(H), 1'b1);
      check_eq("post_rst_busy", 32'(busy), 32'd0);
      vsync = 1'b0;
      repeat (12) tick();
      check_eq("post_rst_idle", 32'(busy), 32'd0);
      check_eq("post_rst_nodone", 32'(done_seen), 32'(done_tot));
      run_frame(int'(V), -1, 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
